// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline: depth limits, count-width helper
// and the occupancy-counter operation encoding.
package elastic_pipe_pkg;

  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 8;
  localparam int BW_DATA_MIN = 1;
  localparam int BW_DATA_MAX = 64;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Width needed to represent an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic register slot: valid bit plus data register that loads whenever
// it is empty or being drained downstream in the same cycle.
module elastic_stage
  import elastic_pipe_pkg::*;
#(
  parameter int                 BW_DATA = 8,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_ready,
  output logic               o_ready,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_data
);

  logic               valid_reg;
  logic [BW_DATA-1:0] data_reg;

  assign o_ready = !valid_reg || i_ready;
  assign o_valid = valid_reg;
  assign o_data  = data_reg;

  // Data only captures real words so idle stages keep their contents stable.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (i_clr) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (o_ready) begin
      valid_reg <= i_valid;
      if (i_valid) begin
        data_reg <= i_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages with a
// dedicated occupancy counter and synchronous flush.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int                 BW_DATA = 8,
  parameter int                 DEPTH   = 2,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_clr,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [BW_DATA-1:0]          i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [BW_DATA-1:0]          o_data,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH:0]     valid_chain;
  logic [BW_DATA-1:0] data_chain [DEPTH+1];

  assign valid_chain[0] = i_valid;
  assign data_chain[0]  = i_data;

  // Each slot keeps its own ready net so the combinational ready path from
  // the output back to stage 0 is a chain of distinct signals.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic rdy_out;
    logic rdy_dn;

    if (gi == DEPTH - 1) begin : g_last
      assign rdy_dn = i_ready;
    end else begin : g_mid
      assign rdy_dn = g_stage[gi+1].rdy_out;
    end

    elastic_stage #(
      .BW_DATA (BW_DATA),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (i_clr),
      .i_valid (valid_chain[gi]),
      .i_data  (data_chain[gi]),
      .i_ready (rdy_dn),
      .o_ready (rdy_out),
      .o_valid (valid_chain[gi+1]),
      .o_data  (data_chain[gi+1])
    );
  end

  assign o_ready = g_stage[0].rdy_out && !i_clr;
  assign o_valid = valid_chain[DEPTH];
  assign o_data  = data_chain[DEPTH];

  logic          xfer_in;
  logic          xfer_out;
  cnt_op_e       cnt_op;
  logic [CW-1:0] count_reg;

  assign xfer_in  = i_valid && o_ready;
  assign xfer_out = o_valid && i_ready;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (i_clr) begin
      cnt_op = CNT_CLR;
    end else if (xfer_in && !xfer_out) begin
      cnt_op = CNT_INC;
    end else if (xfer_out && !xfer_in) begin
      cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_reg <= '0;
    end else begin
      case (cnt_op)
        CNT_INC: count_reg <= count_reg + CW'(1);
        CNT_DEC: count_reg <= count_reg - CW'(1);
        CNT_CLR: count_reg <= '0;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_count = count_reg;

endmodule

// File: tb/tb_elastic_pipe.sv
// Drives eight elastic_pipe instances (DEPTH 1..8) with shared stimulus and
// checks each against a word-position queue model plus hand-computed values.
module tb_elastic_pipe;

  localparam logic [7:0] RST = 8'hE5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr;
  logic       vin;
  logic [7:0] din;
  logic       rdy;

  logic       ov_a [8];
  logic       or_a [8];
  logic [7:0] od_a [8];
  logic [3:0] oc_a [8];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dut
    logic [elastic_pipe_pkg::cnt_width(gi+1)-1:0] cnt;
    elastic_pipe #(
      .BW_DATA (8),
      .DEPTH   (gi + 1),
      .RST_VAL (RST)
    ) u_dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_clr   (clr),
      .i_valid (vin),
      .o_ready (or_a[gi]),
      .i_data  (din),
      .o_valid (ov_a[gi]),
      .i_ready (rdy),
      .o_data  (od_a[gi]),
      .o_count (cnt)
    );
    assign oc_a[gi] = 4'(cnt);
  end

  task automatic check(input string name, input int dep,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s depth=%0d got=%0h want=%0h t=%0t", name, dep, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: per instance, the held words oldest-first with their slot index.
  int         n_w   [8];
  int         wpos  [8][9];
  logic [7:0] wdat  [8][9];
  logic [7:0] last_out [8];

  always @(negedge clk) begin : p_cmp
    int         kn, q, p, np;
    int         kpos [9];
    logic [7:0] kdat [9];
    logic [7:0] lo;
    logic       exp_rdy;
    for (int d = 0; d < 8; d++) begin
      if (!rstn) begin
        n_w[d]      = 0;
        last_out[d] = RST;
      end
      check("m_valid", d + 1, 32'(ov_a[d]), (n_w[d] > 0 && wpos[d][0] == d) ? 1 : 0);
      check("m_data",  d + 1, 32'(od_a[d]), 32'(last_out[d]));
      check("m_count", d + 1, 32'(oc_a[d]), n_w[d]);
      if (rstn) begin
        kn = 0;
        q  = d + 1;
        lo = last_out[d];
        for (int i = 0; i < n_w[d]; i++) begin
          p = wpos[d][i];
          if (i == 0 && p == d && rdy) continue;
          np = (q > p + 1) ? p + 1 : p;
          if (np == d && p != d) lo = wdat[d][i];
          kpos[kn] = np;
          kdat[kn] = wdat[d][i];
          kn++;
          q = np;
        end
        exp_rdy = !clr && (q > 0);
        check("m_ready", d + 1, 32'(or_a[d]), 32'(exp_rdy));
        if (clr) begin
          n_w[d]      = 0;
          last_out[d] = RST;
        end else begin
          if (vin && exp_rdy) begin
            kpos[kn] = 0;
            kdat[kn] = din;
            if (d == 0) lo = din;
            kn++;
          end
          for (int i = 0; i < kn; i++) begin
            wpos[d][i] = kpos[i];
            wdat[d][i] = kdat[i];
          end
          n_w[d]      = kn;
          last_out[d] = lo;
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 8; d++) begin
      n_w[d]      = 0;
      last_out[d] = RST;
    end
    rstn = 1'b1; clr = 1'b0; vin = 1'b0; din = 8'h00; rdy = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("rst_valid", 2, 32'(ov_a[1]), 0);
    check("rst_data",  2, 32'(od_a[1]), 32'(RST));
    check("rst_count", 2, 32'(oc_a[1]), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("rst_ready", 2, 32'(or_a[1]), 1);

    // Back-to-back stream 0x01..0x10 with the sink always ready.
    for (int j = 1; j <= 18; j++) begin
      if (j >= 3) begin
        check("stream_valid", 2, 32'(ov_a[1]), 1);
        check("stream_data",  2, 32'(od_a[1]), j - 2);
      end else begin
        check("stream_lat", 2, 32'(ov_a[1]), 0);
      end
      vin = (j <= 16);
      din = 8'(j);
      tick();
    end
    check("empty_valid", 2, 32'(ov_a[1]), 0);
    check("empty_hold",  2, 32'(od_a[1]), 32'h10);

    // Fill DEPTH=3 against a stalled sink, then release.
    clr = 1'b1; vin = 1'b0;
    tick();
    clr = 1'b0;
    check("clr_count", 3, 32'(oc_a[2]), 0);
    check("clr_data",  3, 32'(od_a[2]), 32'(RST));
    rdy = 1'b0;
    din = 8'hA1; vin = 1'b1;
    tick();
    din = 8'hA2;
    tick();
    din = 8'hA3;
    tick();
    din = 8'hA4;
    #1;
    check("full_ready", 3, 32'(or_a[2]), 0);
    check("full_count", 3, 32'(oc_a[2]), 3);
    tick();
    check("stall_ready", 3, 32'(or_a[2]), 0);
    check("stall_data",  3, 32'(od_a[2]), 32'hA1);
    rdy = 1'b1;
    #1;
    check("release_ready", 3, 32'(or_a[2]), 1);
    tick();
    vin = 1'b0;
    check("drain_a2", 3, 32'(od_a[2]), 32'hA2);
    tick();
    check("drain_a3", 3, 32'(od_a[2]), 32'hA3);
    tick();
    check("drain_a4", 3, 32'(od_a[2]), 32'hA4);
    check("drain_v",  3, 32'(ov_a[2]), 1);
    tick();
    check("drained", 3, 32'(ov_a[2]), 0);

    // Full DEPTH=2 with simultaneous in/out for five cycles.
    clr = 1'b1;
    tick();
    clr = 1'b0; rdy = 1'b0;
    din = 8'hB0; vin = 1'b1;
    tick();
    din = 8'hB1;
    tick();
    check("fill_count", 2, 32'(oc_a[1]), 2);
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] e;
      e   = (k < 2) ? 8'(8'hB0 + k) : 8'(8'hC0 + k - 2);
      din = 8'(8'hC0 + k);
      #1;
      check("thru_ready", 2, 32'(or_a[1]), 1);
      check("thru_data",  2, 32'(od_a[1]), 32'(e));
      tick();
      check("thru_count", 2, 32'(oc_a[1]), 2);
    end

    // Flush with a competing input word 0x55.
    rdy = 1'b0; clr = 1'b1; vin = 1'b1; din = 8'h55;
    #1;
    check("clr_ready", 2, 32'(or_a[1]), 0);
    tick();
    clr = 1'b0; vin = 1'b0;
    check("flush_valid", 2, 32'(ov_a[1]), 0);
    check("flush_count", 2, 32'(oc_a[1]), 0);
    check("flush_data",  2, 32'(od_a[1]), 32'(RST));
    rdy = 1'b1;
    repeat (4) tick();
    check("flush_quiet", 2, 32'(ov_a[1]), 0);

    // Asynchronous reset in the middle of a stream.
    vin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 8'(8'h30 + k);
      tick();
    end
    #1 rstn = 1'b0;
    #1;
    for (int d = 0; d < 8; d++) begin
      check("arst_valid", d + 1, 32'(ov_a[d]), 0);
      check("arst_data",  d + 1, 32'(od_a[d]), 32'(RST));
      check("arst_count", d + 1, 32'(oc_a[d]), 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    din = 8'h77; vin = 1'b1;
    #1;
    check("rel_ready", 2, 32'(or_a[1]), 1);
    tick();
    vin = 1'b0;
    check("rel_lat1", 2, 32'(ov_a[1]), 0);
    tick();
    check("rel_valid2", 2, 32'(ov_a[1]), 1);
    check("rel_data2",  2, 32'(od_a[1]), 32'h77);
    check("rel_lat3",   3, 32'(ov_a[2]), 0);
    tick();
    check("rel_valid3", 3, 32'(ov_a[2]), 1);
    check("rel_data3",  3, 32'(od_a[2]), 32'h77);

    // Random traffic on all depths; the model checks every cycle.
    for (int c = 0; c < 10000; c++) begin
      vin = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    vin = 1'b0; clr = 1'b0; rdy = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 The block SHALL have parameter BW_DATA, default 8, data width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 The block SHALL have parameter RST_VAL, default 0, BW_DATA-wide value loaded into every data register on reset and clear.
REQ-004 The block SHALL have port i_clk, input, 1 bit, clock, all state updates on rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1 bit, reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_clr, input, 1 bit, synchronous flush of all stages.
REQ-007 The block SHALL have port i_valid, input, 1 bit, upstream word valid.
REQ-008 The block SHALL have port o_ready, output, 1 bit, block accepts a word this cycle.
REQ-009 The block SHALL have port i_data, input, BW_DATA bits, upstream word.
REQ-010 The block SHALL have port o_valid, output, 1 bit, last stage holds a word.
REQ-011 The block SHALL have port i_ready, input, 1 bit, downstream accepts a word.
REQ-012 The block SHALL have port o_data, output, BW_DATA bits, last-stage data register.
REQ-013 The block SHALL have port o_count, output, clog2(DEPTH+1) bits, number of occupied stages.

Function
REQ-014 Each stage k SHALL hold one valid bit and one BW_DATA data register; stage 0 faces input, stage DEPTH-1 drives o_valid/o_data directly from registers.
REQ-015 Transfer in SHALL occur on a rising edge when i_valid=1 and o_ready=1; transfer out when o_valid=1 and i_ready=1.
REQ-016 Stage k SHALL load from stage k-1 (or i_data for k=0) when stage k is empty or stage k is emptying this cycle (bubble collapsing).
REQ-017 o_ready SHALL equal (stage 0 empty) OR (stage 0 advances this cycle); combinational ready path through all stages, no cycle penalty.
REQ-018 Unstalled latency SHALL be DEPTH cycles from accepted input to o_valid; sustained throughput one word per cycle.
REQ-019 A stage that neither loads nor empties SHALL hold data and valid unchanged; data SHALL never be dropped or duplicated.
REQ-020 Words SHALL exit in acceptance order.
REQ-021 o_count SHALL update each edge by +1 on transfer in only, -1 on transfer out only, unchanged on both or neither; range 0..DEPTH.
REQ-022 Full (o_count=DEPTH) with i_ready=1: o_ready SHALL be 1 and simultaneous in/out SHALL keep o_count=DEPTH.
REQ-023 Full with i_ready=0: o_ready SHALL be 0.
REQ-024 Empty: o_valid SHALL be 0; o_data SHALL remain at its last value (RST_VAL after reset/clear).
REQ-025 i_clr=1 SHALL on the next edge clear all valid bits, load RST_VAL into all data registers, set o_count=0, and discard any same-cycle input; o_ready SHALL be 0 while i_clr=1.
REQ-026 i_data SHALL be registered only on a stage-0 load; data registers of empty stages SHALL not toggle otherwise.

Reset
REQ-027 On i_rstn=0, asynchronously: all valid bits 0, all data registers RST_VAL, o_valid=0, o_data=RST_VAL, o_count=0.
REQ-028 o_ready SHALL be 1 at the first edge after i_rstn deasserts (when i_clr=0); reset mid-stream SHALL discard all held words.

Structure
REQ-029 A shared package/header SHALL hold the clog2 count-width function and DEPTH range limits; no per-module duplication.
REQ-030 One sub-module elastic_stage (valid + data register, load/hold/clear, ready-out) SHALL be instantiated DEPTH times via generate.
REQ-031 o_count SHALL be a dedicated counter register, not a popcount of valid bits.

Verification
REQ-032 BW_DATA=8, DEPTH=2: i_ready=1, stream 0x01..0x10 back-to-back -> o_valid first rises 2 cycles after first accept, outputs 0x01..0x10 in order, one per cycle.
REQ-033 DEPTH=3, i_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> first three accepted, o_count=3, o_ready=0 on fourth; release i_ready -> 0xA1,0xA2,0xA3 then 0xA4.
REQ-034 Full DEPTH=2, i_valid=1 and i_ready=1 for 5 cycles -> o_count stays 2, no lost or duplicated word.
REQ-035 Two words held, i_clr=1 with i_valid=1, data 0x55 -> next edge o_valid=0, o_count=0, o_data=RST_VAL, 0x55 never appears.
REQ-036 Assert i_rstn=0 asynchronously mid-stream (between edges) -> outputs reach reset values immediately; after release, fresh stream 0x77 exits with DEPTH-cycle latency.
REQ-037 Random i_valid/i_ready (50%) for 10000 cycles, DEPTH=1..8 -> scoreboard order match, o_count equals reference occupancy every cycle.
